// File: rtl/banco_wb_arbiter.sv
// rtl/banco_wb_arbiter.sv - register file write-port arbiter (WB vs MDU) with MDU pending-write scoreboard
module banco_wb_arbiter #(
  parameter int STARVE_LIM = 3,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_reg,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic              iss_valid,
  input  logic [4:0]        iss_reg,
  output logic              iss_ready,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic              hazard_stall,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [5:0]        pend_count,
  output logic              err_sticky
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  logic [31:0] pend;
  logic [31:0] pendNext;
  logic [3:0]  starve;
  logic [3:0]  starveNext;
  logic        wbGrant;
  logic        mduGrant;
  logic        issFire;
  logic        errNext;
  logic [5:0]  countNext;

  // Grants are gated by reset_n so requests held across reset are not accepted.
  always_comb begin
    wbGrant  = reset_n && wb_valid && !(mdu_valid && (starve == StarveLim));
    mduGrant = reset_n && mdu_valid && (!wb_valid || (starve == StarveLim));
    issFire  = reset_n && iss_valid && !pend[iss_reg];

    pendNext = pend;
    if (issFire && (iss_reg != 5'd0)) pendNext[iss_reg] = 1'b1;
    if (mduGrant) pendNext[mdu_reg] = 1'b0;

    starveNext = starve;
    if (!mdu_valid || mduGrant) starveNext = 4'd0;
    else if (starve != StarveLim) starveNext = starve + 4'd1;

    errNext = err_sticky
            | (wbGrant && pend[wb_reg])
            | (mduGrant && (mdu_reg != 5'd0) && !pend[mdu_reg]);

    countNext = 6'd0;
    for (int i = 0; i < 32; i++) countNext = countNext + {5'd0, pendNext[i]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= '0;
      starve     <= '0;
      err_sticky <= 1'b0;
      pend_count <= '0;
    end else begin
      pend       <= pendNext;
      starve     <= starveNext;
      err_sticky <= errNext;
      pend_count <= countNext;
    end
  end

  always_comb begin
    wb_ready  = wbGrant;
    mdu_ready = mduGrant;
    iss_ready = issFire;
    rf_waddr  = 5'd0;
    rf_wdata  = '0;
    if (mduGrant) begin
      rf_waddr = mdu_reg;
      rf_wdata = mdu_data;
    end else if (wbGrant) begin
      rf_waddr = wb_reg;
      rf_wdata = wb_data;
    end
    rf_we = (wbGrant || mduGrant) && (rf_waddr != 5'd0);
    hazard_stall = reset_n
                 && (((rs_addr != 5'd0) && pend[rs_addr])
                  || ((rt_addr != 5'd0) && pend[rt_addr]));
  end

endmodule
